// File: rtl/ifstmt_word_rx.sv
// Bit-serial framed word receiver: assembles a WIDTH-bit word LSB first, optionally
// checks a trailing parity bit, and presents the word with a one-cycle valid pulse.
module ifstmt_word_rx #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin_start,
  input  logic             sin_data,
  output logic [WIDTH-1:0] a,
  output logic             a_valid,
  output logic             parity_err,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  function automatic logic equal(input integer x, input integer y);
    return x == y;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             a_valid_q, a_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             busy_q, busy_d;
  logic             last_c;
  logic             par_ok_c;

  assign last_c   = equal(int'(count_q), int'(WIDTH) - 1);
  assign par_ok_c = (((^shreg_q) ^ sin_data) == 1'(PARITY_ODD));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      count_q      <= '0;
      a_q          <= '0;
      a_valid_q    <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      count_q      <= count_d;
      a_q          <= a_d;
      a_valid_q    <= a_valid_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next state; a start beat restarts a frame from any state
  always_comb begin
    state_d = state_q;
    if (sin_valid) begin
      if (sin_start) begin
        state_d = SHIFT;
      end else if (state_q == SHIFT) begin
        if (last_c) begin
          if (PARITY_EN != 0) begin
            state_d = PAR;
          end else begin
            state_d = IDLE;
          end
        end
      end else if (state_q == PAR) begin
        state_d = IDLE;
      end
    end
  end

  // Shift register, bit counter and registered completion outputs
  always_comb begin
    shreg_d      = shreg_q;
    count_d      = count_q;
    a_d          = a_q;
    a_valid_d    = 1'b0;
    parity_err_d = 1'b0;
    busy_d       = (state_d != IDLE);
    if (sin_valid) begin
      if (sin_start) begin
        shreg_d    = '0;
        shreg_d[0] = sin_data;
        count_d    = CW'(1);
      end else if (state_q == SHIFT) begin
        shreg_d[count_q] = sin_data;
        if (last_c) begin
          count_d = '0;
          if (PARITY_EN == 0) begin
            a_d       = shreg_d;
            a_valid_d = 1'b1;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end else if (state_q == PAR) begin
        if (par_ok_c) begin
          a_d       = shreg_q;
          a_valid_d = 1'b1;
        end else begin
          parity_err_d = 1'b1;
        end
      end
    end
  end

  assign a          = a_q;
  assign a_valid    = a_valid_q;
  assign parity_err = parity_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ifstmt_word_rx.sv
// Scoreboard bench for ifstmt_word_rx: a 32-bit even-parity instance and an 8-bit
// no-parity instance, driven with directed frames; a monitor checks every pulse.
module tb_ifstmt_word_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, s0, d0, v1, s1, d1;
  logic [31:0] a0;
  logic [7:0]  a1;
  logic        av0, pe0, b0, av1, pe1, b1;

  always #5 clk = ~clk;

  ifstmt_word_rx #(.WIDTH(32), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .sin_valid(v0), .sin_start(s0), .sin_data(d0),
    .a(a0), .a_valid(av0), .parity_err(pe0), .busy(b0)
  );

  ifstmt_word_rx #(.WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .sin_valid(v1), .sin_start(s1), .sin_data(d1),
    .a(a1), .a_valid(av1), .parity_err(pe1), .busy(b1)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] val;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   pulse_cyc[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
  endtask

  // Monitor: every completion pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (av0 && pe0) chk("dut0_pulse_exclusive", 32'd1, 32'd0);
      if (av1 && pe1) chk("dut1_pulse_exclusive", 32'd1, 32'd0);
      if (av0) pulse_cyc.push_back(cyc);
      if (av0 || pe0) begin
        if (q0.size() == 0) begin
          chk("dut0_unexpected_pulse", 32'({pe0, av0}), 32'd0);
        end else begin
          e0 = q0.pop_front();
          chk("dut0_kind", 32'(pe0), 32'(e0.err));
          chk("dut0_a", a0, e0.val);
        end
      end
      if (av1 || pe1) begin
        if (q1.size() == 0) begin
          chk("dut1_unexpected_pulse", 32'({pe1, av1}), 32'd0);
        end else begin
          e1 = q1.pop_front();
          chk("dut1_kind", 32'(pe1), 32'(e1.err));
          chk("dut1_a", 32'(a1), e1.val);
        end
      end
    end
  end

  task automatic beat0(input logic st, input logic d);
    v0 = 1'b1; s0 = st; d0 = d;
    @(posedge clk); #1;
  endtask

  task automatic idle0(input int n);
    v0 = 1'b0; s0 = 1'b0; d0 = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat1(input logic st, input logic d);
    v1 = 1'b1; s1 = st; d1 = d;
    @(posedge clk); #1;
  endtask

  task automatic frame0(input logic [31:0] w, input logic p);
    beat0(1'b1, w[0]);
    chk("busy_after_start", 32'(b0), 32'd1);
    for (int i = 1; i < 32; i++) beat0(1'b0, w[i]);
    beat0(1'b0, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] w8;
    int         stall_at;

    rst = 1'b1;
    v0 = 1'b0; s0 = 1'b0; d0 = 1'b0;
    v1 = 1'b0; s1 = 1'b0; d1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a0", a0, 32'd0);
    chk("reset_av0", 32'(av0), 32'd0);
    chk("reset_pe0", 32'(pe0), 32'd0);
    chk("reset_busy0", 32'(b0), 32'd0);
    chk("reset_a1", 32'(a1), 32'd0);
    chk("reset_busy1", 32'(b1), 32'd0);
    rst = 1'b0;
    idle0(2);

    // Good even-parity frame: popcount(DEADBEEF)=24, parity bit 0
    q0.push_back('{err: 1'b0, val: 32'hDEADBEEF});
    frame0(32'hDEADBEEF, 1'b0);
    idle0(0);
    chk("t1_valid_latency", 32'(av0), 32'd1);
    chk("t1_busy_done", 32'(b0), 32'd0);
    idle0(3);

    // Bad parity: a holds DEADBEEF, parity_err pulses
    q0.push_back('{err: 1'b1, val: 32'hDEADBEEF});
    frame0(32'hDEADBEEF, 1'b1);
    idle0(0);
    chk("t2_perr_latency", 32'(pe0), 32'd1);
    chk("t2_no_valid", 32'(av0), 32'd0);
    idle0(3);

    // 8-bit no-parity frame with three stall cycles mid-frame
    w8 = 8'hA5;
    stall_at = $urandom_range(1, 6);
    q1.push_back('{err: 1'b0, val: 32'h000000A5});
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        v1 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
      end
      beat1(i == 0, w8[i]);
    end
    v1 = 1'b0; s1 = 1'b0; d1 = 1'b0;
    chk("t3_valid_latency", 32'(av1), 32'd1);
    chk("t3_a_value", 32'(a1), 32'h000000A5);
    chk("t3_busy_done", 32'(b1), 32'd0);
    idle0(3);

    // Restart: 10 beats of ones abandoned by a new start beat
    q0.push_back('{err: 1'b0, val: 32'h00000001});
    beat0(1'b1, 1'b1);
    repeat (9) beat0(1'b0, 1'b1);
    frame0(32'h00000001, 1'b1);
    idle0(0);
    chk("t4_valid", 32'(av0), 32'd1);
    idle0(3);

    // Back-to-back frames: pulses 33 cycles apart
    pulse_cyc.delete();
    q0.push_back('{err: 1'b0, val: 32'h12345678});
    q0.push_back('{err: 1'b0, val: 32'h0000FFFF});
    frame0(32'h12345678, 1'b1);
    frame0(32'h0000FFFF, 1'b0);
    idle0(3);
    chk("t5_pulse_count", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2)
      chk("t5_pulse_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd33);

    // Reset at beat 20 aborts the frame, then a clean frame
    beat0(1'b1, 1'b1);
    repeat (19) beat0(1'b0, 1'b1);
    rst = 1'b1;
    v0 = 1'b0;
    @(posedge clk); #1;
    chk("t6_reset_a", a0, 32'd0);
    chk("t6_reset_busy", 32'(b0), 32'd0);
    chk("t6_reset_valid", 32'(av0), 32'd0);
    rst = 1'b0;
    idle0(1);
    q0.push_back('{err: 1'b0, val: 32'h00000003});
    frame0(32'h00000003, 1'b0);
    idle0(3);
    chk("t6_final_a", a0, 32'h00000003);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ifstmt_word_rx.md
Name: ifstmt_word_rx

Overview:
- Bit-serial receiver that reassembles a WIDTH-bit word, LSB first, from a framed serial stream.
- Optionally checks a trailing parity bit.
- Presents the word on output reg `a` with a one-cycle valid pulse.
- Serves as the receiving end for word-producing test modules. Its control path deliberately uses nested if/else and a constant-evaluable function (`equal`) in conditions, so it also exercises the if-statement transformation passes on clocked logic.

Parameters:
- WIDTH, 32, payload word width; legal range 2..32.
- PARITY_EN, 1, 1 = expect one parity bit after the payload; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity over payload plus parity bit; 1 = odd parity.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- sin_valid  input  1  sin_data/sin_start are sampled only when high.
- sin_start  input  1  marks the first payload bit of a frame; qualified by sin_valid.
- sin_data  input  1  serial data bit.
- a  output  WIDTH  last received word; output reg.
- a_valid  output  1  one-cycle pulse: a updated with a good word.
- parity_err  output  1  one-cycle pulse: frame completed with bad parity.
- busy  output  1  high while a frame is in progress (state SHIFT or PAR).

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, a=0, a_valid=0, parity_err=0, busy=0, shift register=0, bit counter=0. Reset wins over all other inputs and aborts any frame in progress.
- Internal function `equal(integer x, integer y)` returns (x==y). It is used for all counter/terminal-count comparisons.
- Beats are cycles with sin_valid=1. Cycles with sin_valid=0 are stalls: state, counter, and shift register hold, and outputs do not pulse.
- IDLE:
  - A beat with sin_start=1 loads sin_data into bit 0, sets count=1, and moves to SHIFT.
  - A beat with sin_start=0 is ignored.
- SHIFT:
  - Each beat stores sin_data at bit position count, then count++.
  - On the beat where equal(count, WIDTH-1):
    - if PARITY_EN=1, go to PAR;
    - else go to IDLE with a ← assembled word and a_valid=1 in the next cycle.
- PAR:
  - The next beat is the parity bit p. Compute ok = (^word ^ p) == PARITY_ODD.
  - If ok: a ← word and a_valid pulses. Otherwise: a holds its old value and parity_err pulses.
  - Return to IDLE.
- Latency: a and its pulse are registered, so they appear the cycle after the final beat's edge.
- Restart: sin_start=1 on a beat in SHIFT or PAR abandons the current frame without pulsing either output. That beat becomes bit 0 of a new frame (count=1, state SHIFT).
- Back-to-back frames: a start beat in the cycle immediately after completion is accepted in IDLE with no gap. The a_valid pulse for the previous frame and the capture of the new bit 0 occur in the same cycle.
- a_valid and parity_err are never high simultaneously. Each is high for exactly one cycle per completed frame.
- busy=1 in SHIFT and PAR. busy=0 in IDLE, including the cycle in which a completion pulse is asserted.

Test Plan:
- Reset, then a frame with WIDTH=32, PARITY_EN=1, even parity: payload 0xDEADBEEF LSB first, parity bit 0 (popcount 24, even) → a=0xDEADBEEF and a_valid=1 for one cycle; parity_err=0; busy 1→0.
- Same frame with parity bit 1 → parity_err pulses once, a stays at its prior value, a_valid=0.
- PARITY_EN=0, WIDTH=8: payload 0xA5 with sin_valid low for 3 random cycles mid-frame → a=0x000000A5 one cycle after the 8th beat; the stalls do not shift the result.
- Restart: 10 beats of 1s, then a sin_start beat beginning a frame of 0x00000001 (parity 1) → only one a_valid pulse, with a=0x00000001; no parity_err.
- Back-to-back: two complete frames, 0x12345678 then 0x0000FFFF, with zero idle cycles between them → two a_valid pulses exactly 33 cycles apart, carrying the correct values.
- Assert rst at beat 20 of a frame, then send a full frame 0x00000003 → no pulse from the aborted frame; a=0 after reset, then a=0x00000003.
